regfile_sb: RTL and testbench

//  32-entry general-purpose register file with a write-pending scoreboard.
//  - Sink of the writeback bundle (write addr / enable / data) at the end of the MEM/WB pipeline.
//  - Two read ports serve the ID stage.
//  - Scoreboard tracks destinations issued but not yet written back.
//  - Raises stall_req when ID reads a pending register.

---
 rtl/regfile_sb_if.sv | 30 +++
 rtl/regfile_sb.sv | 78 +++++++
 tb/tb_regfile_sb.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bundle of writeback, read, issue and scoreboard signals between the pipeline and regfile_sb.
interface regfile_sb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              flush;
  logic              stall_req;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2, iss_valid, iss_addr, flush,
    input  rdata1, rdata2, stall_req, pend_cnt
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2, iss_valid, iss_addr, flush,
    output rdata1, rdata2, stall_req, pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// 32-entry register file (r0 hardwired zero) with a write-pending scoreboard and read-hazard stall.
// Optional same-cycle writeback-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  logic [DATA_W-1:0]  r_regs [REG_NUM];
  logic [REG_NUM-1:0] r_pend;
  logic [ADDR_W:0]    r_pend_cnt;
  logic [REG_NUM-1:0] w_pend_nxt;
  logic               w_wr_en;
  logic               w_hit1;
  logic               w_hit2;
  logic               w_stall1;
  logic               w_stall2;

  function automatic logic [ADDR_W:0] f_popcnt(input logic [REG_NUM-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < REG_NUM; i++) c = c + (ADDR_W+1)'(v[i]);
    return c;
  endfunction

  assign w_wr_en = bus.we && (bus.waddr != '0);

`ifdef REGFILE_BYPASS_EN
  assign w_hit1 = bus.we && (bus.waddr == bus.raddr1) && (bus.raddr1 != '0);
  assign w_hit2 = bus.we && (bus.waddr == bus.raddr2) && (bus.raddr2 != '0);
`else
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif

  // Later rules override earlier ones: writeback clear, then issue set, then flush.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_en) w_pend_nxt[bus.waddr] = 1'b0;
    if (bus.iss_valid && (bus.iss_addr != '0)) w_pend_nxt[bus.iss_addr] = 1'b1;
    if (bus.flush) w_pend_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= f_popcnt(w_pend_nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[bus.waddr] <= bus.wdata;
    end
  end

  // Reads and stall are gated by rst so outputs are zero while reset is held.
  assign bus.rdata1 = (rst || !bus.re1 || (bus.raddr1 == '0)) ? '0 :
                      (w_hit1 ? bus.wdata : r_regs[bus.raddr1]);
  assign bus.rdata2 = (rst || !bus.re2 || (bus.raddr2 == '0)) ? '0 :
                      (w_hit2 ? bus.wdata : r_regs[bus.raddr2]);

  assign w_stall1 = !rst && bus.re1 && (bus.raddr1 != '0) && r_pend[bus.raddr1] && !w_hit1;
  assign w_stall2 = !rst && bus.re2 && (bus.raddr2 != '0) && r_pend[bus.raddr2] && !w_hit2;

  assign bus.stall_req = w_stall1 || w_stall2;
  assign bus.pend_cnt  = r_pend_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized bench for regfile_sb against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile_sb;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RN = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  regfile_sb #(.REG_NUM(RN), .ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] m_regs [RN];
  bit            m_pend [RN];
  int            n_assert = 0;
  int            n_fail   = 0;

  function automatic logic [DW-1:0] exp_rd(input logic re, input logic [AW-1:0] a);
    if (rst || !re || a == 0) return '0;
    if (BYP && bus.we && bus.waddr == a) return bus.wdata;
    return m_regs[a];
  endfunction

  function automatic logic exp_hz(input logic re, input logic [AW-1:0] a);
    if (rst || !re || a == 0) return 1'b0;
    return m_pend[a] && !(BYP && bus.we && bus.waddr == a);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < RN; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check(input string tag);
    chk({tag, "_rd1"},   64'(bus.rdata1), 64'(exp_rd(bus.re1, bus.raddr1)));
    chk({tag, "_rd2"},   64'(bus.rdata2), 64'(exp_rd(bus.re2, bus.raddr2)));
    chk({tag, "_stall"}, 64'(bus.stall_req),
        64'(exp_hz(bus.re1, bus.raddr1) || exp_hz(bus.re2, bus.raddr2)));
    chk({tag, "_cnt"},   64'(bus.pend_cnt), 64'(m_count()));
  endtask

  task automatic model_clear();
    for (int i = 0; i < RN; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (bus.we && bus.waddr != 0) begin
        m_regs[bus.waddr] = bus.wdata;
        m_pend[bus.waddr] = 1'b0;
      end
      if (bus.iss_valid && bus.iss_addr != 0) m_pend[bus.iss_addr] = 1'b1;
      if (bus.flush) for (int i = 0; i < RN; i++) m_pend[i] = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    bus.we = 0; bus.waddr = '0; bus.wdata = '0;
    bus.re1 = 0; bus.raddr1 = '0; bus.re2 = 0; bus.raddr2 = '0;
    bus.iss_valid = 0; bus.iss_addr = '0; bus.flush = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_clear();
    #2;
    check("rst_hold");
    tick();
    rst = 1'b0;

    // 1: async reset clears data immediately
    bus.we = 1; bus.waddr = 5; bus.wdata = 32'hDEADBEEF; bus.re1 = 1; bus.raddr1 = 5;
    #1 check("t1_wr");
    tick();
    bus.we = 0;
    #1 chk("t1_rd5", 64'(bus.rdata1), 64'h0000_0000_DEAD_BEEF);
    rst = 1'b1;
    model_clear();
    #1 chk("t1_rst_rd", 64'(bus.rdata1), 64'h0);
    check("t1_rst");
    tick();
    rst = 1'b0;
    #1 chk("t1_post_rd", 64'(bus.rdata1), 64'h0);
    check("t1_post");

    // 2: r0 is inert
    bus.we = 1; bus.waddr = 0; bus.wdata = 32'h1234; bus.iss_valid = 1; bus.iss_addr = 0;
    bus.re1 = 1; bus.raddr1 = 0; bus.re2 = 1; bus.raddr2 = 0;
    #1 check("t2_a");
    tick();
    idle(); bus.re1 = 1; bus.raddr1 = 0;
    #1 chk("t2_cnt", 64'(bus.pend_cnt), 64'h0);
    chk("t2_rd0", 64'(bus.rdata1), 64'h0);
    check("t2_b");

    // 3: pending read stalls until writeback
    idle(); bus.iss_valid = 1; bus.iss_addr = 7;
    tick();
    idle(); bus.re1 = 1; bus.raddr1 = 7;
    #1 chk("t3_stall", 64'(bus.stall_req), 64'h1);
    chk("t3_cnt", 64'(bus.pend_cnt), 64'h1);
    bus.we = 1; bus.waddr = 7; bus.wdata = 32'hA5A5A5A5;
    #1 chk("t3_wb_stall", 64'(bus.stall_req), 64'(!BYP));
    check("t3_wb");
    tick();
    bus.we = 0;
    #1 chk("t3_after_rd", 64'(bus.rdata1), 64'h0000_0000_A5A5_A5A5);
    chk("t3_after_stall", 64'(bus.stall_req), 64'h0);

    // 4: same-edge issue and writeback keeps the mark
    idle(); bus.iss_valid = 1; bus.iss_addr = 3; bus.we = 1; bus.waddr = 3; bus.wdata = 32'h11;
    tick();
    idle(); bus.re1 = 1; bus.raddr1 = 3;
    #1 chk("t4_rd", 64'(bus.rdata1), 64'h11);
    chk("t4_stall", 64'(bus.stall_req), 64'h1);
    check("t4");
    idle(); bus.flush = 1;
    tick();

    // 5: flush beats concurrent issue
    idle(); bus.iss_valid = 1; bus.iss_addr = 1; tick();
    bus.iss_addr = 2; tick();
    bus.iss_addr = 4; tick();
    idle();
    #1 chk("t5_cnt3", 64'(bus.pend_cnt), 64'd3);
    bus.flush = 1; bus.iss_valid = 1; bus.iss_addr = 9;
    tick();
    idle(); bus.re1 = 1; bus.raddr1 = 1; bus.re2 = 1; bus.raddr2 = 9;
    #1 chk("t5_cnt0", 64'(bus.pend_cnt), 64'd0);
    chk("t5_stall", 64'(bus.stall_req), 64'h0);

    // 6: read enable gates the hazard
    idle(); bus.iss_valid = 1; bus.iss_addr = 6; tick();
    idle(); bus.re1 = 0; bus.raddr1 = 6; bus.re2 = 1; bus.raddr2 = 8;
    #1 chk("t6_off", 64'(bus.stall_req), 64'h0);
    bus.re1 = 1;
    #1 chk("t6_on", 64'(bus.stall_req), 64'h1);
    check("t6");
    idle(); bus.flush = 1; tick();

    // Random traffic on a narrow address window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      bus.we        = ($urandom_range(0, 2) != 0);
      bus.waddr     = AW'($urandom_range(0, 7));
      bus.wdata     = $urandom;
      bus.re1       = ($urandom_range(0, 3) != 0);
      bus.raddr1    = AW'($urandom_range(0, 7));
      bus.re2       = ($urandom_range(0, 3) != 0);
      bus.raddr2    = AW'($urandom_range(0, 7));
      bus.iss_valid = ($urandom_range(0, 1) != 0);
      bus.iss_addr  = AW'($urandom_range(0, 7));
      bus.flush     = ($urandom_range(0, 15) == 0);
      #1 check("rnd");
      tick();
    end

    idle();
    #1 check("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
